// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - op codes, rd_sel values and latency defaults for the multiply/divide unit
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - controller-side request and HI/LO result bundle of the multiply/divide unit
interface md_unit_if;

  logic        start;
  logic [2:0]  MD_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_out;

  modport master (
    output start, MD_op, A, B, rd_sel,
    input  busy, HI, LO, MD_out
  );

  modport slave (
    input  start, MD_op, A, B, rd_sel,
    output busy, HI, LO, MD_out
  );

endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO; result computed at launch, committed after latency
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic               div_zero;

  always_comb begin
    a_sx     = {{32{md.A[31]}}, md.A};
    b_sx     = {{32{md.B[31]}}, md.B};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'd0, md.A} * {32'd0, md.B};
    div_zero = (md.B == 32'd0);
    quo_s    = 32'sd0;
    rem_s    = 32'sd0;
    quo_u    = 32'd0;
    rem_u    = 32'd0;
    // Divider is only evaluated with a nonzero divisor so div-by-zero never reaches the operator.
    if (!div_zero) begin
      quo_s = $signed(md.A) / $signed(md.B);
      rem_s = $signed(md.A) % $signed(md.B);
      quo_u = md.A / md.B;
      rem_u = md.A % md.B;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d       = 1'b0;
        {hi_d, lo_d} = pend_q;
      end
    end else if (md.start) begin
      case (md.MD_op)
        MD_MULT: begin
          pend_d = prod_s;
          cnt_d  = CNT_W'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        MD_MULTU: begin
          pend_d = prod_u;
          cnt_d  = CNT_W'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        // A zero divisor still takes full latency but commits the current HI/LO back.
        MD_DIV: begin
          pend_d = div_zero ? {hi_q, lo_q} : {rem_s, quo_s};
          cnt_d  = CNT_W'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        MD_DIVU: begin
          pend_d = div_zero ? {hi_q, lo_q} : {rem_u, quo_u};
          cnt_d  = CNT_W'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        MD_MTHI: hi_d = md.A;
        MD_MTLO: lo_d = md.A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= 64'd0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  assign md.busy   = busy_q;
  assign md.HI     = hi_q;
  assign md.LO     = lo_q;
  assign md.MD_out = md.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  md_unit_if md_if ();

  md_unit #(
    .MULT_CYCLES (MD_MULT_CYCLES),
    .DIV_CYCLES  (MD_DIV_CYCLES),
    .CNT_W       (MD_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pulses start for one edge; returns at the falling edge right after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.MD_op = op;
    md_if.A     = a;
    md_if.B     = b;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.MD_op = MD_NONE;
  endtask

  // Expects busy for n more falling edges, then idle with the given HI/LO.
  task automatic run_busy(input string tag, input int n, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (md_if.busy === 1'b1) seen++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(seen), 32'(n));
    check({tag, "_busy_done"}, {31'd0, md_if.busy}, 32'd0);
    check({tag, "_hi"}, md_if.HI, hi_exp);
    check({tag, "_lo"}, md_if.LO, lo_exp);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    md_if.start  = 1'b0;
    md_if.MD_op  = MD_NONE;
    md_if.A      = 32'd0;
    md_if.B      = 32'd0;
    md_if.rd_sel = RD_LO;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, md_if.busy}, 32'd0);
    check("rst_hi", md_if.HI, 32'd0);
    check("rst_lo", md_if.LO, 32'd0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'h2);
    run_busy("t1_mult", MD_MULT_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
    check("t2_hi_stale", md_if.HI, 32'hFFFF_FFFF);
    run_busy("t2_multu", MD_MULTU == MD_MULTU ? MD_MULT_CYCLES : 0, 32'h1, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    run_busy("t3_div", MD_DIV_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MD_DIVU, 32'hFFFF_FFF9, 32'h2);
    run_busy("t3b_divu", MD_DIV_CYCLES, 32'h1, 32'h7FFF_FFFC);

    issue(MD_DIV, 32'h7, 32'hFFFF_FFFE);
    run_busy("div_negb", MD_DIV_CYCLES, 32'h1, 32'hFFFF_FFFD);

    issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
    run_busy("mult_min", MD_MULT_CYCLES, 32'h4000_0000, 32'h0);

    issue(MD_MTLO, 32'h1234, 32'h0);
    check("t4_mtlo_lo", md_if.LO, 32'h1234);
    check("t4_mtlo_busy", {31'd0, md_if.busy}, 32'd0);
    issue(MD_MTHI, 32'h1, 32'h0);
    check("t4_mthi_hi", md_if.HI, 32'h1);
    issue(MD_DIVU, 32'h7, 32'h0);
    run_busy("t4_div0", MD_DIV_CYCLES, 32'h1, 32'h1234);
    md_if.rd_sel = RD_LO;
    #1 check("t4_mdout_lo", md_if.MD_out, 32'h1234);
    md_if.rd_sel = RD_HI;
    #1 check("t4_mdout_hi", md_if.MD_out, 32'h1);

    issue(MD_NONE, 32'hAAAA_AAAA, 32'h5);
    check("none_busy", {31'd0, md_if.busy}, 32'd0);
    check("none_hi", md_if.HI, 32'h1);
    issue(3'd7, 32'hAAAA_AAAA, 32'h5);
    check("bad_op_lo", md_if.LO, 32'h1234);

    issue(MD_MULT, 32'd3, 32'd4);
    issue(MD_MTHI, 32'hDEAD, 32'h0);
    check("t5_mthi_ignored", md_if.HI, 32'h1);
    md_if.rd_sel = RD_HI;
    #1 check("t5_mdout_stale", md_if.MD_out, 32'h1);
    run_busy("t5_mult", MD_MULT_CYCLES - 2, 32'h0, 32'hC);

    issue(MD_MTHI, 32'h55, 32'h0);
    issue(MD_MULT, 32'd3, 32'd4);
    #2 reset = 1'b1;
    #1;
    check("t6_busy_async", {31'd0, md_if.busy}, 32'd0);
    check("t6_hi_async", md_if.HI, 32'd0);
    check("t6_lo_async", md_if.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (MD_MULT_CYCLES + 2) @(negedge clk);
    check("t6_busy_after", {31'd0, md_if.busy}, 32'd0);
    check("t6_hi_after", md_if.HI, 32'd0);
    check("t6_lo_after", md_if.LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
